// File: rtl/diff_pkg.sv
// Shared types for the difftest commit queue: queued entry layout, drain FSM states
// and the index/mask widths used by the bridge.
package diff_pkg;

  localparam int DIFF_IDX_W  = 8;
  localparam int DIFF_MASK_W = 8;
  localparam int DIFF_XLEN   = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [DIFF_XLEN-1:0]   pc;
    logic [31:0]            instr;
    logic                   skip;
    logic                   wen;
    logic [7:0]             wdest;
    logic [DIFF_XLEN-1:0]   wdata;
    logic                   csr_rstat;
    logic [DIFF_XLEN-1:0]   csr_data;
    logic [DIFF_MASK_W-1:0] st_valid;
    logic [DIFF_XLEN-1:0]   st_paddr;
    logic [DIFF_XLEN-1:0]   st_vaddr;
    logic [DIFF_XLEN-1:0]   st_data;
    logic [7:0]             st_len;
    logic [DIFF_MASK_W-1:0] ld_valid;
    logic [DIFF_XLEN-1:0]   ld_paddr;
    logic [DIFF_XLEN-1:0]   ld_vaddr;
    logic [DIFF_XLEN-1:0]   ld_data;
    logic [7:0]             ld_len;
    logic                   excp;
    logic                   is_mret;
    logic [31:0]            cause;
    logic [31:0]            intrpt_no;
  } commit_entry_t;

  // A trap retires nothing: it only reports the exception.
  function automatic logic is_trap(input commit_entry_t e);
    return e.excp & ~e.is_mret;
  endfunction

endpackage

// File: rtl/diff_fifo.sv
// Synchronous FIFO of commit entries; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module diff_fifo
  import diff_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  commit_entry_t            i_data,
  input  logic                     i_pop,
  output commit_entry_t            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  commit_entry_t r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/diff_commit_queue.sv
// Difftest commit producer: buffers retired-instruction records and replays them as
// registered one-cycle pulses into the bridge, with a sequence index and halt/drain FSM.
//
// state | meaning
// RUN   | accepting commits while not full
// DRAIN | halt seen; no new commits, emptying the queue
// DONE  | queue drained after halt; sticky until reset
module diff_commit_queue
  import diff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_csr_data,
  input  logic [31:0]     in_instr,
  input  logic            in_skip,
  input  logic            in_wen,
  input  logic            in_csr_rstat,
  input  logic [7:0]      in_wdest,
  input  logic [7:0]      in_st_valid,
  input  logic [7:0]      in_ld_valid,
  input  logic [XLEN-1:0] in_st_paddr,
  input  logic [XLEN-1:0] in_st_vaddr,
  input  logic [XLEN-1:0] in_st_data,
  input  logic [XLEN-1:0] in_ld_paddr,
  input  logic [XLEN-1:0] in_ld_vaddr,
  input  logic [XLEN-1:0] in_ld_data,
  input  logic [7:0]      in_st_len,
  input  logic [7:0]      in_ld_len,
  input  logic            in_excp,
  input  logic            in_is_mret,
  input  logic [31:0]     in_cause,
  input  logic [31:0]     in_intrpt_no,
  input  logic            halt_req,
  output logic [7:0]      out_index,
  output logic            out_instrValid,
  output logic [XLEN-1:0] out_the_pc,
  output logic [31:0]     out_instr,
  output logic            out_skip,
  output logic            out_wen,
  output logic [7:0]      out_wdest,
  output logic [XLEN-1:0] out_wdata,
  output logic            out_csrRstat,
  output logic [XLEN-1:0] out_csrData,
  output logic [7:0]      out_storeIndex,
  output logic [7:0]      out_storeValid,
  output logic [XLEN-1:0] out_storePaddr,
  output logic [XLEN-1:0] out_storeVaddr,
  output logic [XLEN-1:0] out_storeData,
  output logic [7:0]      out_storelen,
  output logic [7:0]      out_loadIndex,
  output logic [7:0]      out_loadValid,
  output logic [XLEN-1:0] out_loadPaddr,
  output logic [XLEN-1:0] out_loadVaddr,
  output logic [XLEN-1:0] out_loadData,
  output logic [7:0]      out_loadLen,
  output logic            out_excp_valid,
  output logic            out_isMret,
  output logic [31:0]     out_intrptNo,
  output logic [31:0]     out_cause,
  output logic [XLEN-1:0] out_exceptionPC,
  output logic [31:0]     out_exceptionInst,
  output logic            drained
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIFF_IDX_W-1:0] IDX_ONE = DIFF_IDX_W'(1);

  commit_entry_t         w_in_entry;
  commit_entry_t         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_trap;
  drain_state_t          r_state;
  drain_state_t          w_state_nxt;
  logic [DIFF_IDX_W-1:0] r_seq;

  always_comb begin
    w_in_entry           = '0;
    w_in_entry.pc        = in_pc;
    w_in_entry.instr     = in_instr;
    w_in_entry.skip      = in_skip;
    w_in_entry.wen       = in_wen;
    w_in_entry.wdest     = in_wdest;
    w_in_entry.wdata     = in_wdata;
    w_in_entry.csr_rstat = in_csr_rstat;
    w_in_entry.csr_data  = in_csr_data;
    w_in_entry.st_valid  = in_st_valid;
    w_in_entry.st_paddr  = in_st_paddr;
    w_in_entry.st_vaddr  = in_st_vaddr;
    w_in_entry.st_data   = in_st_data;
    w_in_entry.st_len    = in_st_len;
    w_in_entry.ld_valid  = in_ld_valid;
    w_in_entry.ld_paddr  = in_ld_paddr;
    w_in_entry.ld_vaddr  = in_ld_vaddr;
    w_in_entry.ld_data   = in_ld_data;
    w_in_entry.ld_len    = in_ld_len;
    w_in_entry.excp      = in_excp;
    w_in_entry.is_mret   = in_is_mret;
    w_in_entry.cause     = in_cause;
    w_in_entry.intrpt_no = in_intrpt_no;
  end

  // No bypass: a full queue refuses input even if it dequeues this cycle.
  assign in_ready = ~w_full && (r_state == RUN);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = ~w_empty;
  assign w_trap   = is_trap(w_head);
  assign drained  = (r_state == DONE);

  diff_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Input is closed in DRAIN, so count<=1 means this edge empties the queue.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (halt_req) w_state_nxt = DRAIN;
      DRAIN:   if (w_count <= CNT_ONE) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_seq <= '0;
    else if (w_pop && !w_trap) r_seq <= r_seq + IDX_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_index         <= '0;
      out_instrValid    <= 1'b0;
      out_the_pc        <= '0;
      out_instr         <= '0;
      out_skip          <= 1'b0;
      out_wen           <= 1'b0;
      out_wdest         <= '0;
      out_wdata         <= '0;
      out_csrRstat      <= 1'b0;
      out_csrData       <= '0;
      out_storeIndex    <= '0;
      out_storeValid    <= '0;
      out_storePaddr    <= '0;
      out_storeVaddr    <= '0;
      out_storeData     <= '0;
      out_storelen      <= '0;
      out_loadIndex     <= '0;
      out_loadValid     <= '0;
      out_loadPaddr     <= '0;
      out_loadVaddr     <= '0;
      out_loadData      <= '0;
      out_loadLen       <= '0;
      out_excp_valid    <= 1'b0;
      out_isMret        <= 1'b0;
      out_intrptNo      <= '0;
      out_cause         <= '0;
      out_exceptionPC   <= '0;
      out_exceptionInst <= '0;
    end else begin
      out_instrValid <= 1'b0;
      out_storeValid <= '0;
      out_loadValid  <= '0;
      out_excp_valid <= 1'b0;
      if (w_pop) begin
        out_index         <= r_seq;
        out_storeIndex    <= r_seq;
        out_loadIndex     <= r_seq;
        out_instrValid    <= ~w_trap;
        out_the_pc        <= w_head.pc;
        out_instr         <= w_head.instr;
        out_skip          <= w_head.skip;
        out_wen           <= w_head.wen;
        out_wdest         <= w_head.wdest;
        out_wdata         <= w_head.wdata;
        out_csrRstat      <= w_head.csr_rstat;
        out_csrData       <= w_head.csr_data;
        out_storeValid    <= w_trap ? '0 : w_head.st_valid;
        out_storePaddr    <= w_head.st_paddr;
        out_storeVaddr    <= w_head.st_vaddr;
        out_storeData     <= w_head.st_data;
        out_storelen      <= w_head.st_len;
        out_loadValid     <= w_trap ? '0 : w_head.ld_valid;
        out_loadPaddr     <= w_head.ld_paddr;
        out_loadVaddr     <= w_head.ld_vaddr;
        out_loadData      <= w_head.ld_data;
        out_loadLen       <= w_head.ld_len;
        out_excp_valid    <= w_head.excp;
        out_isMret        <= w_head.excp & w_head.is_mret;
        out_intrptNo      <= w_head.intrpt_no;
        out_cause         <= w_head.cause;
        out_exceptionPC   <= w_head.pc;
        out_exceptionInst <= w_head.instr;
      end
    end
  end

endmodule

// File: tb/tb_diff_commit_queue.sv
// Directed bench for diff_commit_queue: a vector table of single commits plus
// hand sequences for streaming, index wrap, halt/drain and asynchronous reset.
module tb_diff_commit_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0, in_wdata = '0, in_csr_data = '0;
  logic [31:0] in_instr = '0;
  logic        in_skip = 1'b0, in_wen = 1'b0, in_csr_rstat = 1'b0;
  logic [7:0]  in_wdest = '0, in_st_valid = '0, in_ld_valid = '0;
  logic [63:0] in_st_paddr = '0, in_st_vaddr = '0, in_st_data = '0;
  logic [63:0] in_ld_paddr = '0, in_ld_vaddr = '0, in_ld_data = '0;
  logic [7:0]  in_st_len = '0, in_ld_len = '0;
  logic        in_excp = 1'b0, in_is_mret = 1'b0;
  logic [31:0] in_cause = '0, in_intrpt_no = '0;
  logic        halt_req = 1'b0;

  logic [7:0]  out_index, out_wdest, out_storeIndex, out_storeValid, out_storelen;
  logic [7:0]  out_loadIndex, out_loadValid, out_loadLen;
  logic        out_instrValid, out_skip, out_wen, out_csrRstat, out_excp_valid, out_isMret;
  logic [63:0] out_the_pc, out_wdata, out_csrData, out_storePaddr, out_storeVaddr, out_storeData;
  logic [63:0] out_loadPaddr, out_loadVaddr, out_loadData, out_exceptionPC;
  logic [31:0] out_instr, out_intrptNo, out_cause, out_exceptionInst;
  logic        drained;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  diff_commit_queue #(.DEPTH(4), .XLEN(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_wdata(in_wdata), .in_csr_data(in_csr_data), .in_instr(in_instr),
    .in_skip(in_skip), .in_wen(in_wen), .in_csr_rstat(in_csr_rstat), .in_wdest(in_wdest),
    .in_st_valid(in_st_valid), .in_ld_valid(in_ld_valid),
    .in_st_paddr(in_st_paddr), .in_st_vaddr(in_st_vaddr), .in_st_data(in_st_data),
    .in_ld_paddr(in_ld_paddr), .in_ld_vaddr(in_ld_vaddr), .in_ld_data(in_ld_data),
    .in_st_len(in_st_len), .in_ld_len(in_ld_len), .in_excp(in_excp), .in_is_mret(in_is_mret),
    .in_cause(in_cause), .in_intrpt_no(in_intrpt_no), .halt_req(halt_req),
    .out_index(out_index), .out_instrValid(out_instrValid), .out_the_pc(out_the_pc),
    .out_instr(out_instr), .out_skip(out_skip), .out_wen(out_wen), .out_wdest(out_wdest),
    .out_wdata(out_wdata), .out_csrRstat(out_csrRstat), .out_csrData(out_csrData),
    .out_storeIndex(out_storeIndex), .out_storeValid(out_storeValid),
    .out_storePaddr(out_storePaddr), .out_storeVaddr(out_storeVaddr),
    .out_storeData(out_storeData), .out_storelen(out_storelen),
    .out_loadIndex(out_loadIndex), .out_loadValid(out_loadValid),
    .out_loadPaddr(out_loadPaddr), .out_loadVaddr(out_loadVaddr),
    .out_loadData(out_loadData), .out_loadLen(out_loadLen),
    .out_excp_valid(out_excp_valid), .out_isMret(out_isMret), .out_intrptNo(out_intrptNo),
    .out_cause(out_cause), .out_exceptionPC(out_exceptionPC),
    .out_exceptionInst(out_exceptionInst), .drained(drained)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] wdata;
    logic [7:0]  st_mask;
    logic [7:0]  ld_mask;
    logic        excp;
    logic        mret;
    logic [31:0] cause;
    logic        e_iv;
    logic [7:0]  e_idx;
    logic [7:0]  e_stv;
    logic [7:0]  e_ldv;
    logic        e_exv;
    logic        e_mret;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] wdata,
                       input logic [7:0] st, input logic [7:0] ld, input logic excp,
                       input logic mret, input logic [31:0] cause);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_instr     = instr;
    in_wdata     = wdata;
    in_wen       = ~excp;
    in_wdest     = 8'd1;
    in_st_valid  = st;
    in_ld_valid  = ld;
    in_st_paddr  = 64'h8000_1000;
    in_st_vaddr  = 64'h8000_1000;
    in_st_data   = 64'h1122_3344;
    in_ld_paddr  = 64'h8000_2000;
    in_ld_vaddr  = 64'h8000_2000;
    in_ld_data   = 64'h5566_7788;
    in_st_len    = 8'd8;
    in_ld_len    = 8'd8;
    in_excp      = excp;
    in_is_mret   = mret;
    in_cause     = cause;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    halt_req = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"single", 64'h8000_0000, 32'h0010_0093, 64'd1, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0,
               1'b1, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{"store",  64'h8000_0004, 32'h00a1_2023, 64'd0, 8'h0F, 8'h00, 1'b0, 1'b0, 32'd0,
               1'b1, 8'd1, 8'h0F, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{"load",   64'h8000_0008, 32'h0001_3083, 64'd7, 8'h00, 8'hFF, 1'b0, 1'b0, 32'd0,
               1'b1, 8'd2, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{"trap",   64'h8000_0010, 32'h0000_0073, 64'd0, 8'h03, 8'h01, 1'b1, 1'b0, 32'd11,
               1'b0, 8'd3, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{"mret",   64'h8000_0014, 32'h3020_0073, 64'd0, 8'h00, 8'h00, 1'b1, 1'b1, 32'd0,
               1'b1, 8'd3, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{"after",  64'h8000_0018, 32'h0000_0013, 64'd9, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0,
               1'b1, 8'd4, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset state, while reset is held and right after release.
    #1;
    chk("rst_outs_zero", 64'(|{out_index, out_instrValid, out_the_pc, out_instr, out_wdata,
        out_storeValid, out_loadValid, out_excp_valid, out_isMret, out_cause,
        out_exceptionPC, out_storeIndex, out_loadIndex}), 64'd0);
    chk("rst_drained", 64'(drained), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Vector table: one commit into an empty queue, pulse next cycle, idle after.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(tbl[i].pc, tbl[i].instr, tbl[i].wdata, tbl[i].st_mask, tbl[i].ld_mask,
            tbl[i].excp, tbl[i].mret, tbl[i].cause);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      chk({tbl[i].name, ".instrValid"}, 64'(out_instrValid), 64'(tbl[i].e_iv));
      chk({tbl[i].name, ".index"},      64'(out_index),      64'(tbl[i].e_idx));
      chk({tbl[i].name, ".storeIndex"}, 64'(out_storeIndex), 64'(tbl[i].e_idx));
      chk({tbl[i].name, ".loadIndex"},  64'(out_loadIndex),  64'(tbl[i].e_idx));
      chk({tbl[i].name, ".storeValid"}, 64'(out_storeValid), 64'(tbl[i].e_stv));
      chk({tbl[i].name, ".loadValid"},  64'(out_loadValid),  64'(tbl[i].e_ldv));
      chk({tbl[i].name, ".excp_valid"}, 64'(out_excp_valid), 64'(tbl[i].e_exv));
      chk({tbl[i].name, ".isMret"},     64'(out_isMret),     64'(tbl[i].e_mret));
      chk({tbl[i].name, ".the_pc"},     out_the_pc,          tbl[i].pc);
      chk({tbl[i].name, ".instr"},      64'(out_instr),      64'(tbl[i].instr));
      chk({tbl[i].name, ".wdata"},      out_wdata,           tbl[i].wdata);
      if (tbl[i].excp) begin
        chk({tbl[i].name, ".exceptionPC"},   out_exceptionPC,         tbl[i].pc);
        chk({tbl[i].name, ".exceptionInst"}, 64'(out_exceptionInst),  64'(tbl[i].instr));
        chk({tbl[i].name, ".cause"},         64'(out_cause),          64'(tbl[i].cause));
      end
      @(negedge clock);
      chk({tbl[i].name, ".idle_iv"},   64'(out_instrValid), 64'd0);
      chk({tbl[i].name, ".idle_exv"},  64'(out_excp_valid), 64'd0);
      chk({tbl[i].name, ".idle_stv"},  64'(out_storeValid | out_loadValid), 64'd0);
      chk({tbl[i].name, ".idle_hold"}, out_the_pc, tbl[i].pc);
    end

    // Back-to-back: 6 commits with in_valid held; pulses for k-2 at negedge k.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        chk("b2b.instrValid", 64'(out_instrValid), 64'd1);
        chk("b2b.index",      64'(out_index),      64'(k - 2));
        chk("b2b.the_pc",     out_the_pc,          64'h8000_0000 + 64'(4 * (k - 2)));
      end
      if (k < 6) begin
        chk("b2b.in_ready", 64'(in_ready), 64'd1);
        drive(64'h8000_0000 + 64'(4 * k), 32'h0000_0013, 64'(k), 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clock);
    chk("b2b.tail_idle", 64'(out_instrValid), 64'd0);

    // Index wrap: 257 commits, last with a store; emitted index wraps 255 -> 0.
    do_reset();
    for (int k = 0; k < 259; k++) begin
      @(negedge clock);
      if (k == 257) begin
        chk("wrap.idx255",  64'(out_index),      64'd255);
        chk("wrap.stv255",  64'(out_storeValid), 64'd0);
      end
      if (k == 258) begin
        chk("wrap.iv",         64'(out_instrValid), 64'd1);
        chk("wrap.index",      64'(out_index),      64'd0);
        chk("wrap.storeIndex", 64'(out_storeIndex), 64'd0);
        chk("wrap.storeValid", 64'(out_storeValid), 64'h0F);
        chk("wrap.storePaddr", out_storePaddr,      64'h8000_1000);
      end
      if (k < 257)
        drive(64'h8000_0000 + 64'(4 * k), 32'h0000_0013, 64'(k),
              (k == 256) ? 8'h0F : 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
      else
        in_valid = 1'b0;
    end

    // Halt with 3 commits in flight; the 3rd transfer shares the halt cycle.
    do_reset();
    @(negedge clock);
    chk("halt.ready0", 64'(in_ready), 64'd1);
    drive(64'h8000_0100, 32'h0000_0013, 64'd0, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    drive(64'h8000_0104, 32'h0000_0013, 64'd1, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    chk("halt.e0_idx", 64'(out_index), 64'd0);
    drive(64'h8000_0108, 32'h0000_0013, 64'd2, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    chk("halt.ready_drop", 64'(in_ready), 64'd0);
    chk("halt.e1_idx",     64'(out_index), 64'd1);
    chk("halt.e1_iv",      64'(out_instrValid), 64'd1);
    drive(64'h8000_010C, 32'h0000_0013, 64'd3, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    chk("halt.e2_idx", 64'(out_index), 64'd2);
    chk("halt.e2_iv",  64'(out_instrValid), 64'd1);
    chk("halt.e2_pc",  out_the_pc, 64'h8000_0108);
    @(negedge clock);
    chk("halt.no_extra", 64'(out_instrValid), 64'd0);
    chk("halt.drained",  64'(drained), 64'd1);
    chk("halt.ready_lo", 64'(in_ready), 64'd0);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    chk("halt.sticky1", 64'(drained), 64'd1);
    repeat (3) @(negedge clock);
    chk("halt.sticky2", 64'(drained), 64'd1);
    chk("halt.ready_stay", 64'(in_ready), 64'd0);
    chk("halt.idle_iv", 64'(out_instrValid), 64'd0);

    // Asynchronous reset with an entry queued and a pulse on the outputs.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      drive(64'h8000_0200 + 64'(4 * k), 32'h0000_0013, 64'(k), 8'h01, 8'h00, 1'b0, 1'b0, 32'd0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("arst.pre_iv",  64'(out_instrValid), 64'd1);
    chk("arst.pre_idx", 64'(out_index),      64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst.outs_zero", 64'(|{out_index, out_instrValid, out_the_pc, out_instr, out_wdata,
        out_storeValid, out_loadValid, out_excp_valid, out_storeIndex, out_storePaddr}), 64'd0);
    chk("arst.drained", 64'(drained), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("arst.no_stale", 64'(out_instrValid), 64'd0);
    chk("arst.ready",    64'(in_ready),       64'd1);
    drive(64'h8000_0300, 32'h0010_0093, 64'd1, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("arst.first_iv",  64'(out_instrValid), 64'd1);
    chk("arst.first_idx", 64'(out_index),      64'd0);
    chk("arst.first_pc",  out_the_pc,          64'h8000_0300);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
